// File: rtl/mysystem_rom_reader.sv
// Avalon-MM block reader: streams word_count ROM words from base_addr out of an Avalon-ST source.
// First beat READ_LATENCY+2 cycles after start; reads issue only against FIFO credit, so st_ready stalls reach m_read.
module mysystem_rom_reader #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     word_count,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_read,
  output logic [DATA_W/8-1:0] m_byteenable,
  input  logic                m_waitrequest,
  input  logic [DATA_W-1:0]   m_readdata,
  output logic [DATA_W-1:0]   st_data,
  output logic                st_valid,
  input  logic                st_ready,
  output logic                st_last
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nxt;

  logic [ADDR_W:0]         remaining;
  logic [ADDR_W:0]         last_idx;
  logic [ADDR_W:0]         pop_idx;
  logic [CNT_W-1:0]        outstanding;
  logic [CNT_W-1:0]        fifo_count;
  logic [CNT_W:0]          committed;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [READ_LATENCY-1:0] rd_vld;
  logic [DATA_W-1:0]       fifo_mem [FIFO_DEPTH];
  logic                    start_ok, launch, credit, accept, ret, pop, finish;

  assign start_ok = start && !done && (state == IDLE);
  assign launch   = start_ok && (word_count != '0);

  // Every accepted read owns a FIFO slot until it is popped, so the FIFO can never overflow.
  assign committed = {1'b0, outstanding} + {1'b0, fifo_count};
  assign credit    = committed < (CNT_W+1)'(FIFO_DEPTH);
  assign m_read    = (state == RUN) && credit;
  assign accept    = m_read && !m_waitrequest;
  assign ret       = rd_vld[READ_LATENCY-1];

  assign st_valid     = (fifo_count != '0);
  assign st_data      = fifo_mem[rd_ptr];
  assign st_last      = st_valid && (pop_idx == last_idx);
  assign pop          = st_valid && st_ready;
  assign finish       = (state == DRAIN) && (outstanding == '0) && pop && st_last;
  assign busy         = (state != IDLE);
  assign m_byteenable = '1;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = RUN;
      RUN:     if (accept && (remaining == (ADDR_W+1)'(1))) state_nxt = DRAIN;
      DRAIN:   if (finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      done        <= 1'b0;
      m_address   <= '0;
      remaining   <= '0;
      last_idx    <= '0;
      pop_idx     <= '0;
      outstanding <= '0;
      rd_vld      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
    end else begin
      state <= state_nxt;
      done  <= (start_ok && (word_count == '0)) || finish;

      if (launch) begin
        m_address <= base_addr;
        remaining <= word_count;
        last_idx  <= word_count - 1'b1;
        pop_idx   <= '0;
      end else begin
        if (accept) begin
          m_address <= m_address + 1'b1;
          remaining <= remaining - 1'b1;
        end
        if (pop) pop_idx <= pop_idx + 1'b1;
      end

      rd_vld <= READ_LATENCY'({rd_vld, accept});

      case ({accept, ret})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase

      if (ret) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({ret, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ret) fifo_mem[wr_ptr] <= m_readdata;
  end

endmodule

// File: tb/tb_mysystem_rom_reader.sv
// Bench for mysystem_rom_reader: ROM slave model plus a word-index scoreboard of the expected stream.
module tb_mysystem_rom_reader;
  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int RL    = 1;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset, start, m_waitrequest, st_ready;
  logic [AW-1:0]   base_addr, m_address;
  logic [AW:0]     word_count;
  logic            busy, done, m_read, st_valid, st_last;
  logic [DW/8-1:0] m_byteenable;
  logic [DW-1:0]   m_readdata, st_data;

  mysystem_rom_reader #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .word_count(word_count),
    .busy(busy), .done(done), .m_address(m_address), .m_read(m_read), .m_byteenable(m_byteenable),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .st_data(st_data), .st_valid(st_valid),
    .st_ready(st_ready), .st_last(st_last)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] rom [1024];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int exp_base, exp_n, beats, accepts, done_seen, done_cyc, first_beat_cyc, last_beat_cyc;
  int mread_seen, busy_hi, start_cyc, ready_mode, wait_mode, hold_until;
  logic          prev_stall, prev_hold;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Word k of the current transfer lives at (base + k) mod 1024.
  function automatic logic [AW-1:0] waddr(input int k);
    return AW'((exp_base + k) % 1024);
  endfunction

  task automatic reset_obs();
    beats = 0; accepts = 0; done_seen = 0; done_cyc = -1;
    first_beat_cyc = -1; last_beat_cyc = -1; mread_seen = 0; busy_hi = 0;
    prev_stall = 1'b0; prev_hold = 1'b0; prev_addr = '0; prev_data = '0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_m_read", m_read, 0);
    chk("rst_m_address", m_address, 0);
    chk("rst_st_valid", st_valid, 0);
    chk("rst_st_last", st_last, 0);
    chk("byteenable", m_byteenable, 4'hF);
  endtask

  // Observe one cycle at the falling edge, then act as the ROM slave and drive the next cycle's inputs.
  task automatic step();
    logic acc, beat;
    logic [AW-1:0] a;
    @(negedge clk);
    cyc++;
    acc  = m_read && !m_waitrequest;
    beat = st_valid && st_ready;
    a    = m_address;
    if (prev_stall) begin
      chk("read_held_in_wait", m_read, 1);
      chk("addr_held_in_wait", m_address, prev_addr);
    end
    if (prev_hold) begin
      chk("valid_held", st_valid, 1);
      chk("data_held", st_data, prev_data);
    end
    if (acc) begin
      chk("no_extra_read", accepts < exp_n, 1);
      chk("read_addr", m_address, waddr(accepts));
      accepts++;
    end
    if (beat) begin
      chk("no_extra_beat", beats < exp_n, 1);
      chk("beat_data", st_data, rom[waddr(beats)]);
      chk("beat_last", st_last, beats == exp_n - 1);
      if (beats == 0) first_beat_cyc = cyc;
      beats++;
      if (beats == exp_n) last_beat_cyc = cyc;
    end
    chk("buffered_le_depth", (accepts - beats) <= DEPTH, 1);
    if (done) begin
      done_seen++;
      done_cyc = cyc;
      chk("busy_low_at_done", busy, 0);
    end
    if (m_read) mread_seen++;
    if (busy) busy_hi++;
    prev_stall = m_read && m_waitrequest;
    prev_addr  = m_address;
    prev_hold  = st_valid && !st_ready;
    prev_data  = st_data;
    @(posedge clk);
    #1;
    m_readdata = acc ? rom[a] : DW'($urandom);
    case (ready_mode)
      0:       st_ready = 1'b1;
      1:       st_ready = !st_ready;
      2:       st_ready = 1'($urandom_range(0, 1));
      default: st_ready = (cyc >= hold_until);
    endcase
    m_waitrequest = (wait_mode != 0) && ($urandom_range(0, 2) == 0);
  endtask

  task automatic run_xfer(input int base, input int n, input int rmode, input int wmode);
    reset_obs();
    exp_base = base; exp_n = n; ready_mode = rmode; wait_mode = wmode;
    start_cyc  = cyc + 1;
    hold_until = start_cyc + 21;
    st_ready = (rmode != 3);
    m_waitrequest = 1'b0;
    base_addr = AW'(base); word_count = (AW+1)'(n); start = 1'b1;
    step();
    start = 1'b0; base_addr = AW'($urandom); word_count = (AW+1)'($urandom);
    chk("busy_low_in_start_cycle", busy_hi, 0);
    step();
    chk("busy_after_start", busy_hi, n != 0);
    if (rmode == 3) begin
      repeat (20) step();
      chk("credit_stall_reads", accepts, DEPTH);
      chk("credit_stall_beats", beats, 0);
    end
    for (int i = 0; i < 4 * n + 60 && done_seen == 0; i++) step();
    chk("done_seen", done_seen, 1);
    repeat (3) step();
    chk("done_once", done_seen, 1);
    chk("reads_total", accepts, n);
    chk("beats_total", beats, n);
    if (n != 0) begin
      chk("done_after_last_beat", done_cyc, last_beat_cyc + 1);
    end else begin
      chk("zero_done_timing", done_cyc, start_cyc + 1);
      chk("zero_no_read", mread_seen, 0);
      chk("zero_no_busy", busy_hi, 0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
    m_waitrequest = 1'b0; st_ready = 1'b1; m_readdata = '0;
    ready_mode = 0; wait_mode = 0; exp_base = 0; exp_n = 0; start_cyc = 0; hold_until = 0;
    reset_obs();
    for (int i = 0; i < 1024; i++) rom[i] = DW'(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk);
    #1 reset = 1'b0;

    // Identity ROM, full speed: latency and one-word-per-cycle throughput.
    run_xfer(0, 8, 0, 0);
    chk("first_beat_latency", first_beat_cyc, start_cyc + 1 + RL + 1);
    chk("full_rate_stream", last_beat_cyc - first_beat_cyc, 7);

    // Address wrap 1023 -> 0.
    run_xfer(1020, 8, 0, 0);

    for (int i = 0; i < 1024; i++) rom[i] = $urandom;

    // Toggling ready with random waitrequest.
    run_xfer(37, 5, 1, 1);

    // Empty transfer.
    run_xfer(9, 0, 0, 0);

    // Start held through the done cycle: the second start must be ignored.
    reset_obs();
    exp_n = 0; ready_mode = 0; wait_mode = 0;
    base_addr = 5; word_count = '0; start = 1'b1; start_cyc = cyc + 1;
    step();
    step();
    start = 1'b0;
    repeat (3) step();
    chk("start_in_done_ignored", done_seen, 1);
    chk("held_start_done_timing", done_cyc, start_cyc + 1);

    // Full ROM with a stalled consumer at the start.
    run_xfer(0, 1024, 3, 0);

    // Reset in the middle of a transfer, then a clean short transfer.
    reset_obs();
    exp_base = 0; exp_n = 16; ready_mode = 0; wait_mode = 0;
    st_ready = 1'b1; m_waitrequest = 1'b0;
    base_addr = '0; word_count = 16; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 50 && beats < 3; i++) step();
    chk("beats_before_reset", beats, 3);
    chk("no_done_before_reset", done_seen, 0);
    reset = 1'b1;
    #1;
    chk_reset_vals();
    @(posedge clk);
    #1 m_readdata = rom[7];
    @(posedge clk);
    #1 reset = 1'b0;
    chk("no_done_after_reset", done, 0);
    run_xfer(0, 2, 0, 0);

    // Random transfers.
    for (int t = 0; t < 6; t++)
      run_xfer(int'($urandom_range(0, 1023)), int'($urandom_range(1, 40)),
               int'($urandom_range(0, 2)), int'($urandom_range(0, 1)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
